// File: rtl/divmul_arbiter.sv
// divmul_arbiter
// Round-robin arbiter/sequencer that shares one sequential arithmetic unit
// (restoring divider or Booth multiplier) among four requesters. The winning
// requester's operands are latched, the unit is kicked with a one-cycle load
// pulse, and the result is returned with a one-hot, one-cycle valid strobe.
//
// Parameters:
//   WIDTH   - operand width; result width is 2*WIDTH
//   TIMEOUT - watchdog limit in WAIT cycles (only with ARB_TIMEOUT_EN)
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   req[3:0]            - request levels, sampled only in IDLE
//   op_a, op_b          - packed operands, requester k at [k*WIDTH +: WIDTH]
//   gnt[3:0]            - one-hot grant, held LOAD..RESP
//   unit_load           - one-cycle load pulse to the shared unit
//   unit_a, unit_b      - latched operands, stable LOAD..RESP
//   unit_done           - unit completion level
//   unit_result         - unit result, valid while unit_done is high
//   rsp_valid[3:0]      - one-hot, one-cycle response strobe
//   rsp_data            - captured result, held until the next capture
//   busy                - high in every state except IDLE
//   timeout_err         - sticky watchdog flag
//
// Configuration macro: ARB_TIMEOUT_EN enables the WAIT watchdog. Without it
// WAIT holds indefinitely and timeout_err is tied low.
//
// All outputs are registered: every output register is loaded with the value
// belonging to the state being entered, so nothing combinational reaches the
// ports from req or unit_done.

module divmul_arbiter #(
  parameter int WIDTH   = 13,
  parameter int TIMEOUT = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   op_a,
  input  logic [4*WIDTH-1:0]   op_b,
  output logic [3:0]           gnt,
  output logic                 unit_load,
  output logic [WIDTH-1:0]     unit_a,
  output logic [WIDTH-1:0]     unit_b,
  input  logic                 unit_done,
  input  logic [2*WIDTH-1:0]   unit_result,
  output logic [3:0]           rsp_valid,
  output logic [2*WIDTH-1:0]   rsp_data,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         ptr_q, ptr_d;
  logic               unit_load_q, unit_load_d;
  logic [WIDTH-1:0]   unit_a_q, unit_a_d;
  logic [WIDTH-1:0]   unit_b_q, unit_b_d;
  logic [3:0]         rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic               busy_q, busy_d;
  // Marks the first WAIT cycle, where unit_done may still be left over
  // from the previous operation and must be ignored.
  logic               first_q, first_d;

  logic               win_found;
  logic [1:0]         win_idx;
  logic [1:0]         cand;
  logic               wait_done;
  logic               wait_tmo;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_err_q, timeout_err_d;
`endif

  // Round-robin search: ptr, ptr+1, ... (mod 4); the 2-bit add wraps.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign wait_done = (state_q == S_WAIT) && !first_q && unit_done;

`ifdef ARB_TIMEOUT_EN
  // The counter holds k on the (k+1)-th WAIT cycle, so matching TIMEOUT-1
  // leaves WAIT after exactly TIMEOUT cycles.
  assign wait_tmo = (state_q == S_WAIT) && !wait_done &&
                    (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign wait_tmo = 1'b0;
`endif

  // State register (plus the registered outputs that follow it).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      idx_q       <= '0;
      ptr_q       <= '0;
      unit_load_q <= 1'b0;
      unit_a_q    <= '0;
      unit_b_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      unit_load_q <= unit_load_d;
      unit_a_q    <= unit_a_d;
      unit_b_q    <= unit_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      first_q     <= first_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q | wait_tmo;
    if (state_q == S_LOAD) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (win_found) state_d = S_LOAD;
      S_LOAD: state_d = S_WAIT;
      S_WAIT: if (wait_done || wait_tmo) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    gnt_d       = gnt_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    unit_load_d = 1'b0;
    unit_a_d    = unit_a_q;
    unit_b_d    = unit_b_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    busy_d      = (state_d != S_IDLE);
    first_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d       = 4'b0001 << win_idx;
          idx_d       = win_idx;
          unit_a_d    = op_a[int'(win_idx)*WIDTH +: WIDTH];
          unit_b_d    = op_b[int'(win_idx)*WIDTH +: WIDTH];
          unit_load_d = 1'b1;
        end
      end
      S_LOAD: begin
        first_d = 1'b1;
      end
      S_WAIT: begin
        if (wait_done) begin
          rsp_data_d  = unit_result;
          rsp_valid_d = gnt_q;
        end else if (wait_tmo) begin
          rsp_data_d  = '1;
          rsp_valid_d = gnt_q;
        end
      end
      S_RESP: begin
        gnt_d = '0;
        ptr_d = idx_q + 2'd1;
      end
      default: ;
    endcase
  end

  assign gnt       = gnt_q;
  assign unit_load = unit_load_q;
  assign unit_a    = unit_a_q;
  assign unit_b    = unit_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_divmul_arbiter.sv
// Testbench for divmul_arbiter: directed operations against a behavioural
// shared-unit model whose result is {unit_a, unit_b}. Stimulus pushes the
// expected response (strobe, data, cycle) into a scoreboard queue; a monitor
// pops and compares on every rsp_valid.
module tb_divmul_arbiter;
  localparam int W = 13;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      req = '0;
  logic [4*W-1:0]  op_a;
  logic [4*W-1:0]  op_b;
  logic [3:0]      gnt;
  logic            unit_load;
  logic [W-1:0]    unit_a, unit_b;
  logic            unit_done;
  logic [2*W-1:0]  unit_result;
  logic [3:0]      rsp_valid;
  logic [2*W-1:0]  rsp_data;
  logic            busy;
  logic            timeout_err;

  int tests = 0;
  int fails = 0;

  // Shared unit model
  int cyc = 0;
  int load_cyc = -1000;
  int lat_cfg = 14;
  bit stale_en = 1'b0;
  logic [2*W-1:0] res_new = '0;
  logic [2*W-1:0] res_old = '0;

  typedef struct {
    logic [3:0]     v;
    logic [2*W-1:0] d;
    int             c;
  } sb_t;
  sb_t sb_q[$];
  sb_t mon_e;

  divmul_arbiter #(.WIDTH(W), .TIMEOUT(31)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .unit_load(unit_load), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_result(unit_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Done is a level that stays high after completion until the next load.
  // In stale mode it is also forced high (with the old result) on the first
  // WAIT cycle.
  assign unit_done   = (cyc >= load_cyc + lat_cfg) || (stale_en && cyc == load_cyc + 1);
  assign unit_result = (cyc >= load_cyc + lat_cfg) ? res_new : res_old;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (unit_load) begin
      load_cyc <= cyc;
      res_old  <= res_new;
      res_new  <= {unit_a, unit_b};
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && rsp_valid != 4'b0) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b data=%h, expected none (cycle %0d)",
                 rsp_valid, rsp_data, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        $display("[TB] rsp valid=%b data=%h cycle=%0d", rsp_valid, rsp_data, cyc);
        check("rsp_valid", 64'(rsp_valid), 64'(mon_e.v));
        check("rsp_data", 64'(rsp_data), 64'(mon_e.d));
        check("rsp_cycle", 64'(cyc), 64'(mon_e.c));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic wait_load(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!unit_load && n < 200);
    if (!unit_load) check("load_timeout", 64'(unit_load), 64'(1));
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_valid == 4'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (rsp_valid == 4'b0) check("rsp_timeout", 64'(rsp_valid), 64'(1));
  endtask

  // One operation: request, check grant/load, queue expectation, await response.
  task automatic do_op(input logic [3:0] rq, input int k, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int lat, input bit stale,
                       input bit drop);
    int n;
    logic [3:0] oh;
    wait_idle();
    lat_cfg  = lat;
    stale_en = stale;
    op_a[k*W +: W] = a;
    op_b[k*W +: W] = b;
    req = rq;
    wait_load(n);
    oh = 4'b0001 << k;
    $display("[TB] load req=%b gnt=%b a=%0d b=%0d cycle=%0d", rq, gnt, unit_a, unit_b, cyc);
    check("load_latency", 64'(n), 64'(1));
    check("gnt", 64'(gnt), 64'(oh));
    check("unit_a", 64'(unit_a), 64'(a));
    check("unit_b", 64'(unit_b), 64'(b));
    check("busy", 64'(busy), 64'(1));
    sb_q.push_back('{oh, {a, b}, cyc + lat + 1});
    if (drop) req = 4'b0;
    @(negedge clk);
    check("load_pulse", 64'(unit_load), 64'(0));
    wait_rsp();
    req = 4'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 64'(0));
    check({tag, "_unit_load"}, 64'(unit_load), 64'(0));
    check({tag, "_unit_a"}, 64'(unit_a), 64'(0));
    check({tag, "_unit_b"}, 64'(unit_b), 64'(0));
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
  endtask

  initial begin
    int n;
    logic [W-1:0] fa [4];
    logic [W-1:0] fb [4];
    fa = '{13'd11, 13'd22, 13'd33, 13'd44};
    fb = '{13'd5, 13'd6, 13'd7, 13'd8};
    // Distinct background operands so a wrong mux select is visible.
    op_a = {13'd4001, 13'd3001, 13'd2001, 13'd1001};
    op_b = {13'd4002, 13'd3002, 13'd2002, 13'd1002};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single request, 13-cycle divider timing; requester drops req in flight.
    do_op(4'b0100, 2, 13'd100, 13'd7, 14, 1'b0, 1'b1);
    // Pointer wrap: ptr=3, search 3,0,1,2 -> requester 0.
    do_op(4'b0101, 0, 13'd8191, 13'd1, 14, 1'b0, 1'b0);

    // Fairness from reset with all four requesting.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lat_cfg  = 4;
    stale_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      op_a[k*W +: W] = fa[k];
      op_b[k*W +: W] = fb[k];
    end
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_load(n);
      $display("[TB] load req=1111 gnt=%b cycle=%0d", gnt, cyc);
      check("fair_gnt", 64'(gnt), 64'(4'b0001 << (g % 4)));
      sb_q.push_back('{4'b0001 << (g % 4), {fa[g % 4], fb[g % 4]}, cyc + 4 + 1});
      wait_rsp();
      if (g == 4) req = 4'b0;
    end

    // Stale done: ptr=1; done high through LOAD and first WAIT, low 5, then high.
    do_op(4'b0010, 1, 13'd1234, 13'd4321, 7, 1'b1, 1'b0);
    stale_en = 1'b0;

    // Reset five cycles into WAIT: operation aborted, ptr back to 0.
    wait_idle();
    lat_cfg = 1000;
    req = 4'b1000;
    wait_load(n);
    $display("[TB] load req=1000 gnt=%b cycle=%0d (to be aborted)", gnt, cyc);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midwait_rst");
    req = 4'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // With ptr reset to 0 the search 0,1,2,3 picks 1 (not 3).
    do_op(4'b1010, 1, 13'd77, 13'd4095, 5, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: done never comes; response 31 cycles after WAIT entry.
    wait_idle();
    lat_cfg = 1000000;
    req = 4'b0100;
    wait_load(n);
    $display("[TB] load req=0100 gnt=%b cycle=%0d (watchdog)", gnt, cyc);
    check("tmo_gnt", 64'(gnt), 64'(4'b0100));
    sb_q.push_back('{4'b0100, 26'h3FFFFFF, cyc + 32});
    req = 4'b0;
    wait_rsp();
    @(negedge clk);
    check("timeout_err_set", 64'(timeout_err), 64'(1));
    do_op(4'b1001, 3, 13'd9, 13'd10, 6, 1'b0, 1'b0);
    @(negedge clk);
    check("timeout_err_sticky", 64'(timeout_err), 64'(1));
    rst = 1'b1;
    #1;
    check("timeout_err_rst", 64'(timeout_err), 64'(0));
    @(negedge clk);
    rst = 1'b0;
`else
    check("timeout_err_off", 64'(timeout_err), 64'(0));
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "time limit");
  end

endmodule
